// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - single-entry fetch buffer with redirect, flush and misalignment trap
// Optional fetch_count output enabled by IF_PERF_COUNTER_EN.
module instruction_fetch_controller #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_target,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [63:0] if_pc,
   output logic [31:0] if_instr,
   output logic        fetch_error
`ifdef IF_PERF_COUNTER_EN
   ,
   output logic [31:0] fetch_count
`endif
);

   typedef enum logic [1:0] {BOOT, RUN, FLUSH, ERROR} state_t;

   state_t      state;
   logic [63:0] pc;
   logic        redirect_taken;
   logic        misaligned;
   logic        load;
   logic        accept;

   assign imem_addr = pc;

   // BOOT ignores redirects; ERROR ignores everything but reset.
   always_comb begin
      redirect_taken = redirect_valid && (state == RUN || state == FLUSH);
      misaligned     = (redirect_target[1:0] != 2'b00);
      accept         = (state == RUN) && if_valid && if_ready && !redirect_taken;
      load           = !redirect_taken &&
                       ((state == BOOT) || (state == FLUSH) ||
                        ((state == RUN) && (!if_valid || if_ready)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         if_valid    <= 1'b0;
         if_pc       <= 64'h0;
         if_instr    <= 32'h0;
         fetch_error <= 1'b0;
      end else begin
         case (state)
            BOOT, RUN, FLUSH: begin
               if (redirect_taken) begin
                  // The buffered instruction is dropped even if decode is accepting it.
                  if_valid <= 1'b0;
                  if (misaligned) begin
                     state       <= ERROR;
                     fetch_error <= 1'b1;
                  end else begin
                     state <= FLUSH;
                     pc    <= redirect_target;
                  end
               end else if (load) begin
                  state    <= RUN;
                  if_valid <= 1'b1;
                  if_pc    <= pc;
                  if_instr <= imem_data;
                  pc       <= pc + 64'd4;
               end else begin
                  state <= RUN;
               end
            end
            default: begin
               state    <= ERROR;
               if_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef IF_PERF_COUNTER_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= 32'h0;
      end else if (accept && fetch_count != 32'hFFFF_FFFF) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - randomized bench against a stream-level fetch model
// Checks fetch_count as well when IF_PERF_COUNTER_EN is defined.
module tb_instruction_fetch_controller;

   localparam logic [63:0] RP = 64'h0;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [63:0] redirect_target;
   logic        if_valid;
   logic        if_ready;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        fetch_error;
`ifdef IF_PERF_COUNTER_EN
   logic [31:0] fetch_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // model: what the decode side should see
   logic        m_valid;
   logic [63:0] m_pc;
   logic [31:0] m_instr;
   logic [63:0] m_next;
   logic        m_err;
   logic        m_boot;
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
   endfunction

   assign imem_data = mem_word(imem_addr);

   instruction_fetch_controller #(.RESET_PC(RP)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_pc           (if_pc),
      .if_instr        (if_instr),
      .fetch_error     (fetch_error)
`ifdef IF_PERF_COUNTER_EN
      ,
      .fetch_count     (fetch_count)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of behaviour, phrased as stream rules rather than FSM states.
   task automatic model_update();
      if (reset) begin
         m_valid = 1'b0;
         m_next  = RP;
         m_err   = 1'b0;
         m_boot  = 1'b1;
         m_cnt   = 32'h0;
      end else if (m_err) begin
         m_valid = 1'b0;
      end else if (redirect_valid && !m_boot) begin
         m_valid = 1'b0;
         if (redirect_target[1:0] != 2'b00) m_err = 1'b1;
         else m_next = redirect_target;
      end else begin
         if (m_valid && if_ready && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (!m_valid || if_ready || m_boot) begin
            m_valid = 1'b1;
            m_pc    = m_next;
            m_instr = mem_word(m_next);
            m_next  = m_next + 64'd4;
         end
         m_boot = 1'b0;
      end
   endtask

   task automatic check_all();
      chk("if_valid", if_valid, m_valid);
      if (m_valid) begin
         chk("if_pc", if_pc, m_pc);
         chk("if_instr", if_instr, m_instr);
      end
      chk("fetch_error", fetch_error, m_err);
      chk("imem_addr", imem_addr, m_next);
`ifdef IF_PERF_COUNTER_EN
      chk("fetch_count", fetch_count, m_cnt);
`endif
   endtask

   task automatic step(input logic r, input logic rdy, input logic rv, input logic [63:0] tgt);
      reset           = r;
      if_ready        = rdy;
      redirect_valid  = rv;
      redirect_target = tgt;
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic        ok;
      logic [63:0] tgt;
      reset = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 64'h0;
      m_valid = 1'b0; m_pc = 64'h0; m_instr = 32'h0; m_next = RP;
      m_err = 1'b0; m_boot = 1'b1; m_cnt = 32'h0;

      // reset, boot bubble, then 0,4,8,12
      step(1, 1, 0, 0);
      step(1, 1, 1, 64'h40);
      chk("reset_valid", if_valid, 0);
      chk("reset_addr", imem_addr, RP);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0);
         chk("seq_pc", if_pc, 64'(i * 4));
      end

      // back-pressure while if_pc=8
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0);
         chk("stall_pc", if_pc, 64'h8);
      end
      step(0, 1, 0, 0);
      chk("release_pc", if_pc, 64'hC);

      // redirect to 0x20 while 0x10 is offered and accepted
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (if_valid && if_pc == 64'h10) ok = 1'b1;
         else step(0, 1, 0, 0);
      end
      chk("reach_0x10", ok, 1);
      step(0, 1, 1, 64'h20);
      chk("flush_valid", if_valid, 0);
      step(0, 1, 0, 0);
      chk("redir_pc0", if_pc, 64'h20);
      step(0, 1, 0, 0);
      chk("redir_pc1", if_pc, 64'h24);

      // misaligned redirect traps; later redirect ignored; reset recovers
      step(0, 1, 1, 64'h22);
      chk("err_flag", fetch_error, 1);
      step(0, 1, 1, 64'h40);
      step(0, 1, 0, 0);
      chk("err_hold", if_valid, 0);
      step(1, 0, 0, 0);
      chk("err_clear", fetch_error, 0);
      step(0, 1, 0, 0);
      chk("restart_pc", if_pc, RP);

      // wrap at top of address space
      step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
      step(0, 1, 0, 0);
      chk("top_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      step(0, 1, 0, 0);
      chk("wrap_pc", if_pc, 64'h0);
      chk("wrap_err", fetch_error, 0);

`ifdef IF_PERF_COUNTER_EN
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("count5", fetch_count, 5);
      step(1, 1, 0, 0);
      chk("count_rst", fetch_count, 0);
`endif

      // randomized traffic
      step(1, 1, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) tgt = {$urandom, $urandom} | 64'(($urandom_range(1, 3)));
         else if (r < 3) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'({$urandom_range(0, 3), 2'b00});
         else tgt = {$urandom, $urandom} & ~64'h3;
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 14) == 0, tgt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC loaded on reset; must be 4-byte aligned.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_addr  output  64  fetch address to instruction memory, driven combinationally from the PC register.
REQ-005 imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-006 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-007 redirect_target  input  64  new PC; sampled only when redirect_valid=1.
REQ-008 if_valid  output  1  output buffer holds a valid instruction.
REQ-009 if_ready  input  1  decode stage accepts the instruction this cycle.
REQ-010 if_pc  output  64  PC of the buffered instruction.
REQ-011 if_instr  output  32  buffered instruction word.
REQ-012 fetch_error  output  1  sticky misaligned-redirect flag.

Function
REQ-013 The block SHALL implement the states BOOT, RUN, FLUSH and ERROR.
REQ-014 BOOT: entered on reset; lasts exactly one cycle; if_valid=0; then go to RUN.
REQ-015 RUN: the output buffer SHALL load {pc, imem_data} into {if_pc, if_instr}, set if_valid=1 and advance pc by 4 when the buffer is empty or when if_valid=1 and if_ready=1 in that cycle.
REQ-016 RUN: when if_valid=1 and if_ready=0, pc, if_pc, if_instr and if_valid SHALL hold unchanged (no drop, no duplicate).
REQ-017 Sustained throughput SHALL be one instruction per cycle while if_ready=1; latency from pc to if_valid is one cycle.
REQ-018 redirect_valid=1 with redirect_target[1:0]=0 in RUN or FLUSH: pc <= redirect_target, if_valid <= 0, go to FLUSH; the in-flight buffered instruction SHALL be discarded even if if_ready=1 in the same cycle.
REQ-019 FLUSH: lasts one cycle; if_valid=0; the fetch at the new pc is captured at the end of this cycle, so if_valid=1 with if_pc=target on the following cycle; then go to RUN.
REQ-020 Redirect SHALL take priority over the RUN advance/hold rules in the same cycle.
REQ-021 redirect_valid=1 with redirect_target[1:0]!=0: go to ERROR, if_valid <= 0, fetch_error <= 1, pc unchanged.
REQ-022 ERROR: absorbing until reset; if_valid=0; redirect_valid is ignored; fetch_error stays 1.
REQ-023 redirect_valid in BOOT SHALL be ignored.
REQ-024 pc arithmetic SHALL be 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0 without error.
REQ-025 if_pc/if_instr SHALL be don't-care while if_valid=0; the bench checks them only when if_valid=1.

Reset
REQ-026 reset=1 at a rising edge SHALL set: state=BOOT, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0, fetch_error=0, regardless of the current state (including mid-stall, FLUSH or ERROR).
REQ-027 While reset=1, imem_addr SHALL equal RESET_PC from the first clocked edge onward.

Configuration
REQ-028 Macro IF_PERF_COUNTER_EN: when defined, the block SHALL add the output fetch_count (32 bits); fetch_count increments once per accepted handshake (if_valid=1 and if_ready=1, no redirect that cycle), saturates at 32'hFFFF_FFFF, and resets to 0.
REQ-029 When IF_PERF_COUNTER_EN is undefined, fetch_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset with RESET_PC=0, if_ready=1 held -> if_valid=0 for one cycle, then if_pc = 0, 4, 8, 12 on consecutive cycles with if_instr matching the memory words.
REQ-031 Back-pressure: if_ready=0 for 3 cycles while if_pc=8 -> if_pc=8 and if_instr are stable for 3 cycles; after release the next if_pc is 12 (no skip, no repeat).
REQ-032 Redirect to 0x20 while if_pc=0x10 and if_ready=1 -> 0x10 is not counted as accepted, if_valid=0 for one cycle, then if_pc=0x20, 0x24.
REQ-033 Redirect to 0x22 -> fetch_error=1 and if_valid=0 from the next cycle; a later valid redirect to 0x40 has no effect; reset clears fetch_error and restarts at RESET_PC.
REQ-034 pc=64'hFFFF_FFFF_FFFF_FFFC, if_ready=1 -> the next if_pc is 0; fetch_error stays 0.
REQ-035 With IF_PERF_COUNTER_EN defined: 5 accepted handshakes plus 2 stalled cycles -> fetch_count=5; assert reset mid-stream -> fetch_count=0.
